// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
package counter_pkg;

    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_e;

    // 64-bit so that MODULUS = 2**32 (WIDTH=32) is representable.
    function automatic logic [63:0] clamp_mod(input logic [63:0] val, input logic [63:0] modulus);
        return (val >= modulus) ? (modulus - 64'd1) : val;
    endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of param_updown_counter; master drives, slave is the counter.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap_pulse;
    logic             ovf_sticky;

    modport master (
        output en, up, clr, load, load_val, ovf_clr,
        input  count, tc, wrap_pulse, ovf_sticky
    );

    modport slave (
        input  en, up, clr, load, load_val, ovf_clr,
        output count, tc, wrap_pulse, ovf_sticky
    );
endinterface

// File: rtl/counter_next_state.sv
// Combinational next-count mux (clr > load > en) and range-end hit decode.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter longint      MODULUS   = 16,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_nxt,
    output logic             hit
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);
    localparam cnt_mode_e        MODE = SATURATE ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] ld;

    // Clamping the current value too keeps the output in range even from an
    // out-of-range count, so every path of the mux stays below MODULUS.
    assign cur = WIDTH'(clamp_mod(64'(count), 64'(MODULUS)));
    assign ld  = WIDTH'(clamp_mod(64'(load_val), 64'(MODULUS)));

    always_comb begin
        count_nxt = cur;
        hit       = 1'b0;
        if (clr) begin
            count_nxt = RST;
        end else if (load) begin
            count_nxt = ld;
        end else if (en) begin
            if (up) begin
                if (cur == MAX) begin
                    hit       = 1'b1;
                    count_nxt = (MODE == MODE_SAT) ? MAX : '0;
                end else begin
                    count_nxt = cur + WIDTH'(1);
                end
            end else begin
                if (cur == '0) begin
                    hit       = 1'b1;
                    count_nxt = (MODE == MODE_SAT) ? '0 : MAX;
                end else begin
                    count_nxt = cur - WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// Synchronous up/down counter with programmable modulus, wrap/saturate,
// clear/load, cascade terminal count and sticky overflow.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter longint      MODULUS   = 16,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)
        || longint'(RESET_VAL) >= MODULUS) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH/MODULUS/RESET_VAL");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             hit;

    counter_next_state #(
        .WIDTH     (WIDTH),
        .MODULUS   (MODULUS),
        .SATURATE  (SATURATE),
        .RESET_VAL (RESET_VAL)
    ) u_next (
        .count     (count_q),
        .en        (bus.en),
        .up        (bus.up),
        .clr       (bus.clr),
        .load      (bus.load),
        .load_val  (bus.load_val),
        .count_nxt (count_d),
        .hit       (hit)
    );

    // hit already excludes clr/load cycles; a set outranks ovf_clr.
    always_comb begin
        wrap_pulse_d = hit;
        ovf_sticky_d = hit | (ovf_sticky_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= RST;
            wrap_pulse_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.tc         = bus.en & (bus.up ? (count_q == MAX) : (count_q == '0));
endmodule
